// File: rtl/wb_dst_track_pkg.sv
// Shared types and constants for the write-destination tracker.
// Stage records carry {we, rn, load} from ID through WB.
package wb_dst_track_pkg;

    localparam logic [4:0] REG_ZERO        = 5'd0;
    localparam int         RN_W            = 5;
    localparam int         STAGE_W         = RN_W + 2;
    localparam int         STALL_CNT_W_DEF = 16;

    typedef struct packed {
        logic            we;
        logic [RN_W-1:0] rn;
        logic            load;
    } stage_t;

    localparam stage_t STAGE_BUBBLE = '{we: 1'b0, rn: REG_ZERO, load: 1'b0};

    // True when a source operand is actually read and names the given register.
    function automatic logic src_hit(
        input logic            uses,
        input logic [RN_W-1:0] src_rn,
        input logic [RN_W-1:0] dst_rn
    );
        return uses & (src_rn == dst_rn);
    endfunction

endpackage

// File: rtl/wb_dst_stage.sv
// One pipeline stage record {we, rn, load}.
// Priority: rst > cls (hold) > clr (bubble) > load d.
module wb_dst_stage
    import wb_dst_track_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   clr,
    input  logic   cls,
    input  stage_t d,
    output stage_t q
);

    stage_t rec_q;
    stage_t rec_d;

    always_comb begin
        rec_d = rec_q;
        if (cls) begin
            rec_d = rec_q;
        end else if (clr) begin
            rec_d = STAGE_BUBBLE;
        end else begin
            rec_d = d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rec_q <= STAGE_BUBBLE;
        end else begin
            rec_q <= rec_d;
        end
    end

    assign q = rec_q;

endmodule

// File: rtl/wb_dst_track.sv
// Write-destination tracker: EX/MEM/WB destination records, forwarding
// producer outputs, load-use hazard detection and stall counter.
module wb_dst_track
    import wb_dst_track_pkg::*;
#(
    parameter int STALL_CNT_W = STALL_CNT_W_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   pause,
    input  logic                   flush,
    input  logic                   id_we,
    input  logic [4:0]             id_wr_rn,
    input  logic                   id_is_load,
    input  logic [4:0]             id_rs_rn,
    input  logic [4:0]             id_rt_rn,
    input  logic                   id_uses_rs,
    input  logic                   id_uses_rt,
    output logic                   alu_we,
    output logic [4:0]             fw_alu_rn,
    output logic                   mem_We,
    output logic [4:0]             fw_mem_rn,
    output logic                   wb_we,
    output logic [4:0]             wb_rn,
    output logic                   ld_stall,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    stage_t id_rec;
    stage_t ex_rec;
    stage_t mem_rec;
    stage_t wb_rec;
    logic   hazard;
    logic   ex_clr;

    logic [STALL_CNT_W-1:0] stall_cnt_q;
    logic [STALL_CNT_W-1:0] stall_cnt_d;

    // Writes to r0 are dropped here so downstream stages never see them.
    always_comb begin
        id_rec      = STAGE_BUBBLE;
        id_rec.we   = id_we & (id_wr_rn != REG_ZERO);
        id_rec.rn   = id_wr_rn;
        id_rec.load = id_is_load;
    end

    always_comb begin
        hazard = 1'b0;
        if (ex_rec.we && ex_rec.load) begin
            hazard = src_hit(id_uses_rs, id_rs_rn, ex_rec.rn)
                   | src_hit(id_uses_rt, id_rt_rn, ex_rec.rn);
        end
    end

    assign ex_clr = flush | hazard;

    wb_dst_stage u_ex (
        .clk (clk),
        .rst (rst),
        .clr (ex_clr),
        .cls (pause),
        .d   (id_rec),
        .q   (ex_rec)
    );

    wb_dst_stage u_mem (
        .clk (clk),
        .rst (rst),
        .clr (1'b0),
        .cls (pause),
        .d   (ex_rec),
        .q   (mem_rec)
    );

    wb_dst_stage u_wb (
        .clk (clk),
        .rst (rst),
        .clr (1'b0),
        .cls (pause),
        .d   (mem_rec),
        .q   (wb_rec)
    );

    // Counts only unpaused stall cycles; saturates instead of wrapping.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (hazard && !pause && !(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign alu_we    = ex_rec.we & ~ex_rec.load;
    assign fw_alu_rn = ex_rec.rn;
    assign mem_We    = mem_rec.we;
    assign fw_mem_rn = mem_rec.rn;
    assign wb_we     = wb_rec.we;
    assign wb_rn     = wb_rec.rn;
    assign ld_stall  = hazard;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_wb_dst_track.sv
// Directed bench for wb_dst_track: history-queue model checked every
// cycle plus literal expectations at key points of each scenario.
module tb_wb_dst_track;

    localparam int CW  = 4;
    localparam int MAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst, pause, flush;
    logic          id_we, id_is_load, id_uses_rs, id_uses_rt;
    logic [4:0]    id_wr_rn, id_rs_rn, id_rt_rn;
    logic          alu_we, mem_We, wb_we, ld_stall;
    logic [4:0]    fw_alu_rn, fw_mem_rn, wb_rn;
    logic [CW-1:0] stall_cnt;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    wb_dst_track #(.STALL_CNT_W(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .pause      (pause),
        .flush      (flush),
        .id_we      (id_we),
        .id_wr_rn   (id_wr_rn),
        .id_is_load (id_is_load),
        .id_rs_rn   (id_rs_rn),
        .id_rt_rn   (id_rt_rn),
        .id_uses_rs (id_uses_rs),
        .id_uses_rt (id_uses_rt),
        .alu_we     (alu_we),
        .fw_alu_rn  (fw_alu_rn),
        .mem_We     (mem_We),
        .fw_mem_rn  (fw_mem_rn),
        .wb_we      (wb_we),
        .wb_rn      (wb_rn),
        .ld_stall   (ld_stall),
        .stall_cnt  (stall_cnt)
    );

    // Model: the list of records that entered EX, newest last.
    typedef struct {
        bit       we;
        bit [4:0] rn;
        bit       ld;
    } rec_t;

    rec_t hist[$];
    int   m_cnt = 0;

    function automatic rec_t age(int k);
        rec_t z = '{we: 0, rn: 0, ld: 0};
        if (hist.size() > k) return hist[hist.size() - 1 - k];
        return z;
    endfunction

    function automatic bit m_stall();
        rec_t e = age(0);
        if (!(e.we && e.ld)) return 0;
        return (id_uses_rs && id_rs_rn == e.rn) ||
               (id_uses_rt && id_rt_rn == e.rn);
    endfunction

    always @(posedge clk) begin
        rec_t n;
        bit   s;
        if (rst) begin
            hist.delete();
            m_cnt = 0;
        end else if (!pause) begin
            s = m_stall();
            if (s && m_cnt < MAX) m_cnt++;
            if (flush || s) n = '{we: 0, rn: 0, ld: 0};
            else n = '{we: id_we && id_wr_rn != 0, rn: id_wr_rn,
                       ld: id_is_load};
            hist.push_back(n);
            if (hist.size() > 3) void'(hist.pop_front());
        end
    end

    task automatic chk(string nm, int got, int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0d expected %0d", nm, $time, got, exp);
        end
    endtask

    always @(negedge clk) begin
        rec_t e, m, w;
        e = age(0);
        m = age(1);
        w = age(2);
        chk("m_alu_we", alu_we, e.we && !e.ld);
        chk("m_alu_rn", fw_alu_rn, e.rn);
        chk("m_mem_we", mem_We, m.we);
        chk("m_mem_rn", fw_mem_rn, m.rn);
        chk("m_wb_we", wb_we, w.we);
        chk("m_wb_rn", wb_rn, w.rn);
        chk("m_stall", ld_stall, m_stall());
        chk("m_cnt", stall_cnt, m_cnt);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        flush = 0; id_we = 0; id_wr_rn = 0; id_is_load = 0;
        id_rs_rn = 0; id_rt_rn = 0; id_uses_rs = 0; id_uses_rt = 0;
    endtask

    task automatic load(bit [4:0] rn);
        idle();
        id_we = 1; id_wr_rn = rn; id_is_load = 1;
    endtask

    initial begin
        rst = 1; pause = 0;
        idle();
        tick(); tick();
        rst = 0;
        chk("rst_alu_we", alu_we, 0);
        chk("rst_mem_we", mem_We, 0);
        chk("rst_wb_rn", wb_rn, 0);
        chk("rst_cnt", stall_cnt, 0);

        // streaming 5,6,7
        id_we = 1; id_wr_rn = 5; tick();
        chk("s_alu5", fw_alu_rn, 5);
        chk("s_alu_we", alu_we, 1);
        id_wr_rn = 6; tick();
        chk("s_mem5", fw_mem_rn, 5);
        chk("s_alu6", fw_alu_rn, 6);
        id_wr_rn = 7; tick();
        chk("s_wb5", wb_rn, 5);
        chk("s_wb_we", wb_we, 1);
        chk("s_mem6", fw_mem_rn, 6);
        idle(); tick();
        chk("s_wb6", wb_rn, 6);
        tick();
        chk("s_wb7", wb_rn, 7);
        tick();

        // load-use through rs
        load(8); tick();
        chk("lu_alu_we", alu_we, 0);
        chk("lu_ex_rn", fw_alu_rn, 8);
        idle(); id_we = 1; id_wr_rn = 10; id_uses_rs = 1; id_rs_rn = 8; #1;
        chk("lu_stall", ld_stall, 1);
        tick();
        chk("lu_bubble", alu_we, 0);
        chk("lu_mem_we", mem_We, 1);
        chk("lu_mem_rn", fw_mem_rn, 8);
        chk("lu_cnt", stall_cnt, 1);
        chk("lu_stall_off", ld_stall, 0);
        tick();
        chk("lu_user", fw_alu_rn, 10);
        idle(); tick(); tick(); tick();

        // r0 and non-user
        id_we = 1; id_wr_rn = 0; tick();
        chk("r0_alu", alu_we, 0);
        idle(); tick();
        chk("r0_mem", mem_We, 0);
        load(8); tick();
        idle(); id_rs_rn = 8; id_rt_rn = 8; #1;
        chk("nouse_stall", ld_stall, 0);
        tick(); tick(); tick();

        // pause with load-use pending via rt
        load(12); tick();
        idle(); id_we = 1; id_wr_rn = 15; id_uses_rt = 1; id_rt_rn = 12;
        pause = 1; #1;
        chk("p_stall", ld_stall, 1);
        repeat (3) begin
            tick();
            chk("p_hold_stall", ld_stall, 1);
            chk("p_hold_cnt", stall_cnt, 1);
            chk("p_hold_rn", fw_alu_rn, 12);
        end
        pause = 0; tick();
        chk("p_bubble", alu_we, 0);
        chk("p_mem_rn", fw_mem_rn, 12);
        chk("p_cnt", stall_cnt, 2);
        tick();
        chk("p_user", fw_alu_rn, 15);
        idle(); tick(); tick(); tick();

        // flush together with ld_stall, then flush alone
        load(13); tick();
        idle(); flush = 1; id_we = 1; id_wr_rn = 14;
        id_uses_rs = 1; id_rs_rn = 13; tick();
        chk("f_cnt", stall_cnt, 3);
        chk("f_bubble", alu_we, 0);
        idle(); flush = 1; id_we = 1; id_wr_rn = 9; tick();
        chk("f_alone_we", alu_we, 0);
        chk("f_alone_rn", fw_alu_rn, 0);
        idle(); tick(); tick(); tick();

        // saturation
        for (int i = 0; i < 12; i++) begin
            load(8); tick();
            idle(); id_uses_rs = 1; id_rs_rn = 8; tick();
        end
        chk("sat_full", stall_cnt, MAX);
        load(8); tick();
        idle(); id_uses_rt = 1; id_rt_rn = 8; #1;
        chk("sat_stall", ld_stall, 1);
        tick();
        chk("sat_hold", stall_cnt, MAX);

        // reset during pause
        idle(); id_we = 1; id_wr_rn = 3; tick(); tick();
        pause = 1; rst = 1; flush = 1; tick();
        chk("rp_alu", alu_we, 0);
        chk("rp_mem", mem_We, 0);
        chk("rp_alu_rn", fw_alu_rn, 0);
        chk("rp_cnt", stall_cnt, 0);
        rst = 0; pause = 0; idle(); tick();
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
